// File: rtl/mem_read_sequencer_pkg.sv
// Shared definitions for the memory read sequencer: FSM state encoding and sweep
// direction constants.
package mem_read_sequencer_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } seq_state_t;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  // Address the sweep begins from for a given direction.
  function automatic logic [31:0] sweep_origin(input logic dir, input int addr_w);
    logic [31:0] all_ones;
    all_ones = (32'd1 << addr_w) - 32'd1;
    return (dir == DIR_UP) ? 32'd0 : all_ones;
  endfunction

endpackage

// File: rtl/mem_read_sequencer_if.sv
// Memory read port plus output valid/ready stream of the read sequencer.
// master = sequencer side, slave = memory/consumer side.
interface mem_read_sequencer_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
);

  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output mem_rd_en,
    output mem_addr,
    input  mem_rdata,
    output out_data,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  mem_rd_en,
    input  mem_addr,
    output mem_rdata,
    input  out_data,
    input  out_valid,
    output out_ready
  );

endinterface

// File: rtl/mem_read_sequencer_rd_addr_counter.sv
// Up/down read address counter with direction-dependent load and terminal-count flag.
module rd_addr_counter
  import mem_read_sequencer_pkg::*;
#(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              step,
  input  logic              dir,
  output logic [ADDR_W-1:0] count,
  output logic              terminal
);

  logic [31:0] origin;

  assign origin = sweep_origin(dir, ADDR_W);

  // Arithmetic wraps modulo 2**ADDR_W, which continuous sweeps rely on.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= origin[ADDR_W-1:0];
    end else if (step) begin
      if (dir == DIR_UP) begin
        count <= count + ADDR_W'(1);
      end else begin
        count <= count - ADDR_W'(1);
      end
    end
  end

  assign terminal = (dir == DIR_UP) ? (count == '1) : (count == '0);

endmodule

// File: rtl/mem_read_sequencer.sv
// Read-side sweep sequencer: one read per address, word presented on a valid/ready stream.
// Define MEM_READ_WRAP_EN for continuous sweeping terminated by stop.
module mem_read_sequencer
  import mem_read_sequencer_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic up_down,
  input  logic stop,
  output logic busy,
  output logic carry,
  output logic done,
  mem_read_sequencer_if.master bus
);

  seq_state_t        state;
  logic              dir_q;
  logic              cnt_dir;
  logic              cnt_load;
  logic              cnt_step;
  logic              terminal;
  logic              accept;
  logic              keep_going;
  logic [ADDR_W-1:0] count;

  // Direction is taken live from up_down only while loading; afterwards it is frozen.
  assign cnt_dir  = (state == S_IDLE) ? up_down : dir_q;
  assign cnt_load = (state == S_IDLE) && start;
  assign accept   = (state == S_HOLD) && bus.out_valid && bus.out_ready;

`ifdef MEM_READ_WRAP_EN
  assign keep_going = !stop;
`else
  logic unused_stop;
  assign unused_stop = stop;
  assign keep_going  = !terminal;
`endif

  assign cnt_step = accept && keep_going;

  rd_addr_counter #(
    .ADDR_W(ADDR_W)
  ) u_counter (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .step     (cnt_step),
    .dir      (cnt_dir),
    .count    (count),
    .terminal (terminal)
  );

  assign bus.mem_addr = count;

  // Read strobe is raised on entry to READ, so it lasts exactly that one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= S_IDLE;
      dir_q         <= DIR_DN;
      bus.mem_rd_en <= 1'b0;
      bus.out_data  <= '0;
      bus.out_valid <= 1'b0;
      busy          <= 1'b0;
      carry         <= 1'b0;
      done          <= 1'b0;
    end else begin
      bus.mem_rd_en <= 1'b0;
      carry         <= 1'b0;
      done          <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            dir_q         <= up_down;
            state         <= S_READ;
            bus.mem_rd_en <= 1'b1;
            busy          <= 1'b1;
          end
        end
        S_READ: begin
          state <= S_WAIT;
        end
        S_WAIT: begin
          bus.out_data  <= bus.mem_rdata;
          bus.out_valid <= 1'b1;
          state         <= S_HOLD;
        end
        S_HOLD: begin
          if (accept) begin
            bus.out_valid <= 1'b0;
            carry         <= terminal;
            if (keep_going) begin
              state         <= S_READ;
              bus.mem_rd_en <= 1'b1;
            end else begin
              state <= S_IDLE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
